// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction RAM (slave).
// mem_ready is combinational in the memory with respect to mem_addr.
interface inst_fetch_if;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_ce,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_ce,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// OpenMIPS instruction fetch stage: PC, latency-tolerant word fetch, IF/ID register.
// Flush outranks stall, which outranks a memory response.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        branch_target,
    inst_fetch_if.master       imem,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Both bus outputs decode straight from registers, keeping inputs off the address path.
    always_comb begin
        imem.mem_ce   = (state == FETCH);
        imem.mem_addr = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            id_pc     <= '0;
            id_inst   <= '0;
            id_valid  <= 1'b0;
            fetch_cnt <= '0;
        end else if (state == FETCH) begin
            if (flush) begin
                pc       <= {branch_target[31:2], 2'b00};
                id_pc    <= '0;
                id_inst  <= '0;
                id_valid <= 1'b0;
            end else if (stall) begin
                pc        <= pc;
                id_pc     <= id_pc;
                id_inst   <= id_inst;
                id_valid  <= id_valid;
                fetch_cnt <= fetch_cnt;
            end else if (imem.mem_ready) begin
                pc        <= pc + 32'd4;
                id_pc     <= pc;
                id_inst   <= imem.mem_rdata;
                id_valid  <= 1'b1;
                fetch_cnt <= fetch_cnt + 32'd1;
            end else begin
                id_pc    <= '0;
                id_inst  <= '0;
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a wait-state instruction memory model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem          (bus.master),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Memory: ready once the same address has been presented for waitn full cycles.
    logic [31:0] mem [16];
    logic [31:0] cur_addr = '0;
    logic        prev_ce = 1'b0;
    int unsigned wcnt = 0;
    int unsigned waitn = 0;

    always @(negedge clk) begin
        if (bus.mem_ce && prev_ce && bus.mem_addr == cur_addr) wcnt <= wcnt + 1;
        else                                                  wcnt <= 0;
        cur_addr <= bus.mem_addr;
        prev_ce  <= bus.mem_ce;
    end

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    assign bus.mem_ready = bus.mem_ce && (bus.mem_addr == cur_addr) && (wcnt >= waitn);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] cnt);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".pc"},    id_pc,     pc);
        check({tag, ".inst"},  id_inst,   inst);
        check({tag, ".cnt"},   fetch_cnt, cnt);
    endtask

    // Holds rst across one edge, releases it mid-cycle; next posedge is E0.
    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst.ce",   {31'd0, bus.mem_ce}, 32'd0);
        check("rst.addr", bus.mem_addr, 32'h0);
        chk_id("rst", 1'b0, 32'h0, 32'h0, 32'd0);
        #3 rst = 1'b0;
        check("rel.ce", {31'd0, bus.mem_ce}, 32'd0);
        step();
        check("e0.ce",   {31'd0, bus.mem_ce}, 32'd1);
        check("e0.addr", bus.mem_addr, 32'h0);
        check("e0.valid", {31'd0, id_valid}, 32'd0);
    endtask

    initial begin
        for (int unsigned i = 0; i < 16; i++) mem[i] = 32'h3400_0000 + i;
        mem[0]  = 32'h3401_1100;
        mem[1]  = 32'h3402_0020;
        mem[2]  = 32'h3403_ff00;
        mem[3]  = 32'h3404_ffff;
        mem[4]  = 32'h3405_0055;
        mem[15] = 32'hdead_beef;

        // Zero-wait startup
        waitn = 0;
        do_reset();
        step(); chk_id("s1", 1'b1, 32'h0, 32'h3401_1100, 32'd1);
        step(); chk_id("s2", 1'b1, 32'h4, 32'h3402_0020, 32'd2);
        step(); chk_id("s3", 1'b1, 32'h8, 32'h3403_ff00, 32'd3);
        step(); chk_id("s4", 1'b1, 32'hc, 32'h3404_ffff, 32'd4);
        check("s4.addr", bus.mem_addr, 32'h10);

        // Two wait cycles per access
        waitn = 2;
        do_reset();
        step(); chk_id("w.b0", 1'b0, 32'h0, 32'h0, 32'd0);
        check("w.b0.addr", bus.mem_addr, 32'h0);
        step(); chk_id("w.b1", 1'b0, 32'h0, 32'h0, 32'd0);
        step(); chk_id("w.i0", 1'b1, 32'h0, 32'h3401_1100, 32'd1);
        step(); chk_id("w.b2", 1'b0, 32'h0, 32'h0, 32'd1);
        check("w.b2.addr", bus.mem_addr, 32'h4);
        step(); chk_id("w.b3", 1'b0, 32'h0, 32'h0, 32'd1);
        step(); chk_id("w.i1", 1'b1, 32'h4, 32'h3402_0020, 32'd2);

        // Stall for three cycles while IF/ID holds the second word
        waitn = 0;
        do_reset();
        step(); step();
        chk_id("st.pre", 1'b1, 32'h4, 32'h3402_0020, 32'd2);
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk_id("st.hold", 1'b1, 32'h4, 32'h3402_0020, 32'd2);
            check("st.addr", bus.mem_addr, 32'h8);
        end
        stall = 1'b0;
        step(); chk_id("st.rel", 1'b1, 32'h8, 32'h3403_ff00, 32'd3);

        // Flush beats stall and a ready memory; target low bits dropped
        do_reset();
        step(); step();
        flush = 1'b1; stall = 1'b1; branch_target = 32'h0000_0013;
        step();
        flush = 1'b0; stall = 1'b0;
        chk_id("fl.sq", 1'b0, 32'h0, 32'h0, 32'd2);
        check("fl.addr", bus.mem_addr, 32'h10);
        step(); chk_id("fl.tgt", 1'b1, 32'h10, 32'h3405_0055, 32'd3);

        // PC wraps past the top of the address space
        flush = 1'b1; branch_target = 32'hffff_fffc;
        step();
        flush = 1'b0;
        check("wr.addr0", bus.mem_addr, 32'hffff_fffc);
        step(); chk_id("wr.top", 1'b1, 32'hffff_fffc, 32'hdead_beef, 32'd4);
        check("wr.addr1", bus.mem_addr, 32'h0);
        step(); chk_id("wr.zero", 1'b1, 32'h0, 32'h3401_1100, 32'd5);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk_id("ar", 1'b0, 32'h0, 32'h0, 32'd0);
        check("ar.ce",   {31'd0, bus.mem_ce}, 32'd0);
        check("ar.addr", bus.mem_addr, 32'h0);
        #2 rst = 1'b0;
        step();
        check("ar.e0.ce", {31'd0, bus.mem_ce}, 32'd1);
        step(); chk_id("ar.i0", 1'b1, 32'h0, 32'h3401_1100, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the OpenMIPS core, between the instruction RAM and the decode stage. It holds the program counter, issues word reads to instruction memory, tolerates multi-cycle memory latency, and registers each fetched instruction with its PC into the IF/ID pipeline register. It honours stall and branch-redirect requests from downstream.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  decode/execute not accepting; hold PC and IF/ID contents
- flush  in  1  branch/jump taken; redirect PC and squash IF/ID
- branch_target  in  32  redirect byte address, valid when flush=1
- mem_ce  out  1  instruction memory enable
- mem_addr  out  32  byte address of the current fetch (= pc)
- mem_rdata  in  32  instruction word for mem_addr
- mem_ready  in  1  mem_rdata valid for the current mem_addr this cycle
- id_pc  out  32  PC of the instruction held in IF/ID
- id_inst  out  32  instruction held in IF/ID (0 = nop when invalid)
- id_valid  out  1  IF/ID holds a real instruction
- fetch_cnt  out  32  count of instructions delivered to IF/ID

## Operation
- States: IDLE, FETCH.
- Reset (async, while rst=1): state=IDLE, pc=RESET_PC, mem_ce=0, id_pc=0, id_inst=0, id_valid=0, fetch_cnt=0.
- IDLE: mem_ce=0; next cycle -> FETCH unconditionally. flush/stall ignored in IDLE.
- FETCH: mem_ce=1, mem_addr=pc. Per cycle, priority order:
  - flush=1: pc<=branch_target with bits[1:0] forced to 0; id_valid<=0, id_inst<=0, id_pc<=0; fetch_cnt unchanged. Applies even if stall=1 or mem_ready=1 (in-flight word discarded).
  - else stall=1: pc, id_pc, id_inst, id_valid, fetch_cnt all hold.
  - else mem_ready=1: id_inst<=mem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, fetch_cnt<=fetch_cnt+1.
  - else (waiting on memory): id_valid<=0, id_inst<=0, id_pc<=0 (bubble); pc holds.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. fetch_cnt wraps likewise.
- Memory contract: mem_ready is combinational w.r.t. mem_addr; a change of mem_addr aborts any outstanding access. Memory indexes words by mem_addr[31:2].

## Timing
- mem_addr and mem_ce are direct register outputs (no combinational path from inputs).
- Zero-wait memory (mem_ready=1): rst falls before edge E0; E0: IDLE->FETCH; E1: first word at RESET_PC in IF/ID; thereafter one instruction per cycle.
- N-wait memory: instruction latches on the edge where mem_ready=1; N bubbles (id_valid=0) precede it.
- Redirect: flush at edge Ek -> mem_addr=branch_target from after Ek; target instruction in IF/ID at Ek+1 with zero-wait memory; exactly one squashed slot.
- Stall releases: fetch resumes the same cycle stall drops, no lost or duplicated instruction.
- rst asserted mid-operation: all outputs return to reset values immediately (without clock edge).

## Test plan
- Reset/startup: words 0x34011100, 0x34020020, 0x3403ff00, 0x3404ffff at addr 0..3, mem_ready=1, rst high 20 ns -> mem_ce=0 one cycle, then id_inst sequence 0x34011100, 0x34020020, 0x3403ff00, 0x3404ffff with id_pc 0,4,8,12, fetch_cnt=4.
- Memory wait: mem_ready low 2 cycles per access -> each instruction preceded by 2 bubbles (id_valid=0, id_inst=0), pc advances only on ready, order unchanged.
- Stall: stall=1 for 3 cycles while id_inst=0x34020020 -> id_inst/id_pc/pc/fetch_cnt frozen; after release next id_inst=0x3403ff00, id_pc=8.
- Flush priority: flush=1, stall=1, branch_target=0x0000_0013 same cycle -> id_valid=0, mem_addr=0x0000_0010 next cycle, fetch_cnt unchanged; next instruction id_pc=0x10.
- Wrap: flush to 0xFFFF_FFFC, ready=1 -> id_pc=0xFFFF_FFFC, then mem_addr=0x0000_0000.
- Async reset mid-run: rst pulse between clock edges while id_valid=1 -> all outputs at reset values before next edge; restart fetches from RESET_PC.
